// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: request inputs and lamp/status outputs of the
// two-direction traffic-light controller.
// The slave modport is the controller; the master modport drives its
// requests and observes its lamps.
interface traffic_light_ctrl_if;
  logic       hold_i;
  logic       ped_req_i;
  logic       flash_i;
  logic [2:0] ns_o;
  logic [2:0] ew_o;
  logic [2:0] state_o;
  logic       tick_o;
  logic       ped_pending_o;

  modport master (
    output hold_i, ped_req_i, flash_i,
    input  ns_o, ew_o, state_o, tick_o, ped_pending_o
  );

  modport slave (
    input  hold_i, ped_req_i, flash_i,
    output ns_o, ew_o, state_o, tick_o, ped_pending_o
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: north-south / east-west traffic-light controller with
// all-red clearance, pedestrian green shortening and a green-extending hold.
// Timing runs from an internal tick enable derived from the system clock.
// Optional night-flash mode is built only when TRAFFIC_FLASH_MODE_EN is
// defined; otherwise flash_i is ignored and state code 6 is invalid.
// Lamp encoding per direction {green,yellow,red}.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned T_GREEN     = 5,
  parameter int unsigned T_YELLOW    = 2,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_MIN_GREEN = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  traffic_light_ctrl_if.slave  bus
);

  localparam longint unsigned MAX_DUR = longint'(1) << CNT_W;

  if (TICK_DIV == 0 || T_GREEN == 0 || T_YELLOW == 0 || T_ALLRED == 0 ||
      T_MIN_GREEN == 0 || T_MIN_GREEN > T_GREEN ||
      longint'(T_GREEN) > MAX_DUR || longint'(T_YELLOW) > MAX_DUR ||
      longint'(T_ALLRED) > MAX_DUR) begin : g_bad_params
    $error("traffic_light_ctrl: illegal duration/width parameters");
  end

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_MIN    = CNT_W'(T_MIN_GREEN - 1);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
`ifdef TRAFFIC_FLASH_MODE_EN
    ,FLASH    = 3'd6
`endif
  } state_t;

  logic [PW-1:0]    presc_q;
  logic             tick;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pend_q, pend_d;
  logic             green;
  logic             held;
  logic             clamp;
  logic             timer_zero;
  logic [2:0]       ns_lamps, ew_lamps;

`ifdef TRAFFIC_FLASH_MODE_EN
  logic             flash_ph_q, flash_ph_d;
`else
  logic             unused_flash;
  assign unused_flash = bus.flash_i;
`endif

  assign tick       = (presc_q == PRESC_LAST);
  assign green      = (state_q == NS_GREEN) || (state_q == EW_GREEN);
  assign held       = green && bus.hold_i;
  assign clamp      = green && pend_q && (timer_q > LD_MIN);
  assign timer_zero = (timer_q == '0);

  // Free-running tick prescaler, wraps at TICK_DIV-1.
  always_ff @(posedge clk_i) begin
    if (rst_i || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Controller state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= NS_GREEN;
      timer_q    <= LD_GREEN;
      pend_q     <= 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
      flash_ph_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
`ifdef TRAFFIC_FLASH_MODE_EN
      flash_ph_q <= flash_ph_d;
`endif
    end
  end

  // Next state, phase timer and pedestrian latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q || bus.ped_req_i;
`ifdef TRAFFIC_FLASH_MODE_EN
    flash_ph_d = flash_ph_q;
    if (state_q == FLASH) begin
      timer_d = '0;
      if (tick) begin
        if (bus.flash_i) begin
          flash_ph_d = ~flash_ph_q;
        end else begin
          state_d = ALLRED_A;
          timer_d = LD_ALLRED;
        end
      end
    end else if (tick && bus.flash_i) begin
      state_d    = FLASH;
      timer_d    = '0;
      flash_ph_d = 1'b0;
    end else
`endif
    if (clamp) begin
      // Clamp applies every clock, even under hold, so a held green is
      // shortened as soon as hold is released.
      timer_d = LD_MIN;
    end else if (tick && !held) begin
      if (!timer_zero) begin
        timer_d = timer_q - CNT_W'(1);
      end
      case (state_q)
        NS_GREEN:  if (timer_zero) begin state_d = NS_YELLOW; timer_d = LD_YELLOW; end
        NS_YELLOW: if (timer_zero) begin state_d = ALLRED_A;  timer_d = LD_ALLRED; end
        ALLRED_A:  if (timer_zero) begin state_d = EW_GREEN;  timer_d = LD_GREEN;  end
        EW_GREEN:  if (timer_zero) begin state_d = EW_YELLOW; timer_d = LD_YELLOW; end
        EW_YELLOW: if (timer_zero) begin state_d = ALLRED_B;  timer_d = LD_ALLRED; end
        ALLRED_B:  if (timer_zero) begin state_d = NS_GREEN;  timer_d = LD_GREEN;  end
        default: begin
          state_d = ALLRED_A;
          timer_d = LD_ALLRED;
        end
      endcase
    end

    // Entering clearance consumes the request; a request on the same edge survives.
    if ((state_d != state_q) && ((state_d == ALLRED_A) || (state_d == ALLRED_B))) begin
      pend_d = bus.ped_req_i;
    end
`ifdef TRAFFIC_FLASH_MODE_EN
    if (state_d == FLASH) begin
      pend_d = 1'b0;
    end
`endif
  end

  // Lamp decode from the registered state.
  always_comb begin
    ns_lamps = 3'b001;
    ew_lamps = 3'b001;
    case (state_q)
      NS_GREEN:  ns_lamps = 3'b100;
      NS_YELLOW: ns_lamps = 3'b010;
      EW_GREEN:  ew_lamps = 3'b100;
      EW_YELLOW: ew_lamps = 3'b010;
`ifdef TRAFFIC_FLASH_MODE_EN
      FLASH: begin
        ns_lamps = {1'b0, ~flash_ph_q, 1'b0};
        ew_lamps = {1'b0, ~flash_ph_q, 1'b0};
      end
`endif
      default: ;
    endcase
  end

  assign bus.ns_o          = ns_lamps;
  assign bus.ew_o          = ew_lamps;
  assign bus.state_o       = state_q;
  assign bus.tick_o        = tick;
  assign bus.ped_pending_o = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed and randomized checks of traffic_light_ctrl
// against a phase-table reference model. Flash checks are included when
// TRAFFIC_FLASH_MODE_EN is defined.
module tb_traffic_light_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int CNT_W       = 8;
  localparam int T_GREEN     = 5;
  localparam int T_YELLOW    = 2;
  localparam int T_ALLRED    = 1;
  localparam int T_MIN_GREEN = 2;
`ifdef TRAFFIC_FLASH_MODE_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  traffic_light_ctrl_if bus ();

  traffic_light_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .CNT_W      (CNT_W),
    .T_GREEN    (T_GREEN),
    .T_YELLOW   (T_YELLOW),
    .T_ALLRED   (T_ALLRED),
    .T_MIN_GREEN(T_MIN_GREEN)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase index 0..5 walks the six-phase cycle.
  int m_presc, m_ph, m_tmr;
  bit m_pend, m_fl, m_fph;

  function automatic int dur_of(input int ph);
    case (ph)
      0, 3:    return T_GREEN;
      1, 4:    return T_YELLOW;
      default: return T_ALLRED;
    endcase
  endfunction

  function automatic void model_step(input bit r, input bit h, input bit p, input bit f);
    bit tk, grn, was_pend, into_clear;
    if (r) begin
      m_presc = 0; m_ph = 0; m_tmr = T_GREEN - 1;
      m_pend = 0; m_fl = 0; m_fph = 0;
      return;
    end
    tk = (m_presc == TICK_DIV - 1);
    m_presc = tk ? 0 : m_presc + 1;
    grn = !m_fl && (m_ph == 0 || m_ph == 3);
    was_pend = m_pend;
    into_clear = 1'b0;
    m_pend = m_pend | p;
    if (m_fl) begin
      if (tk) begin
        if (f) m_fph = !m_fph;
        else begin m_fl = 0; m_ph = 2; m_tmr = T_ALLRED - 1; into_clear = 1'b1; end
      end
    end else if (FLASH_EN && tk && f) begin
      m_fl = 1; m_fph = 0; m_tmr = 0;
    end else if (grn && was_pend && m_tmr > T_MIN_GREEN - 1) begin
      m_tmr = T_MIN_GREEN - 1;
    end else if (tk && !(grn && h)) begin
      if (m_tmr > 0) m_tmr = m_tmr - 1;
      else begin
        m_ph = (m_ph + 1) % 6;
        m_tmr = dur_of(m_ph) - 1;
        into_clear = (m_ph == 2 || m_ph == 5);
      end
    end
    if (into_clear) m_pend = p;
    if (m_fl) m_pend = 0;
  endfunction

  function automatic logic [2:0] exp_ns();
    if (m_fl) return m_fph ? 3'b000 : 3'b010;
    return (m_ph == 0) ? 3'b100 : (m_ph == 1) ? 3'b010 : 3'b001;
  endfunction

  function automatic logic [2:0] exp_ew();
    if (m_fl) return m_fph ? 3'b000 : 3'b010;
    return (m_ph == 3) ? 3'b100 : (m_ph == 4) ? 3'b010 : 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic cyc(input bit r, input bit h, input bit p, input bit f);
    rst = r; bus.hold_i = h; bus.ped_req_i = p; bus.flash_i = f;
    @(posedge clk);
    model_step(r, h, p, f);
    @(negedge clk);
    chk("state", 32'(bus.state_o), m_fl ? 32'd6 : 32'(m_ph));
    chk("ns", 32'(bus.ns_o), 32'(exp_ns()));
    chk("ew", 32'(bus.ew_o), 32'(exp_ew()));
    chk("tick", 32'(bus.tick_o), 32'(m_presc == TICK_DIV - 1));
    chk("pend", 32'(bus.ped_pending_o), 32'(m_pend));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hl, fl, rr, pp;
    bus.hold_i = 0; bus.ped_req_i = 0; bus.flash_i = 0;

    // Reset then free run
    cyc(1, 0, 0, 0);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_ns", 32'(bus.ns_o), 32'b100);
    chk("rst_ew", 32'(bus.ew_o), 32'b001);
    chk("rst_tick", 32'(bus.tick_o), 32'd0);
    chk("rst_pend", 32'(bus.ped_pending_o), 32'd0);
    repeat (19) cyc(0, 0, 0, 0);
    chk("ns_green_c19", 32'(bus.state_o), 32'd0);
    cyc(0, 0, 0, 0);
    chk("ns_yellow_c20", 32'(bus.state_o), 32'd1);
    chk("ns_yellow_lamp", 32'(bus.ns_o), 32'b010);
    repeat (8) cyc(0, 0, 0, 0);
    chk("allred_a_c28", 32'(bus.state_o), 32'd2);
    repeat (4) cyc(0, 0, 0, 0);
    chk("ew_green_c32", 32'(bus.state_o), 32'd3);
    chk("ew_green_lamp", 32'(bus.ew_o), 32'b100);
    repeat (32) cyc(0, 0, 0, 0);
    chk("cycle_64", 32'(bus.state_o), 32'd0);

    // Hold through NS_GREEN, then hold during NS_YELLOW
    cyc(1, 0, 0, 0);
    repeat (40) cyc(0, 1, 0, 0);
    chk("hold_state", 32'(bus.state_o), 32'd0);
    chk("hold_ns", 32'(bus.ns_o), 32'b100);
    repeat (19) cyc(0, 0, 0, 0);
    chk("hold_rel_c59", 32'(bus.state_o), 32'd0);
    cyc(0, 0, 0, 0);
    chk("hold_rel_c60", 32'(bus.state_o), 32'd1);
    repeat (8) cyc(0, 1, 0, 0);
    chk("hold_yellow", 32'(bus.state_o), 32'd2);

    // Pedestrian pulse at first tick of NS_GREEN
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("ped_set", 32'(bus.ped_pending_o), 32'd1);
    repeat (7) cyc(0, 0, 0, 0);
    chk("ped_c11", 32'(bus.state_o), 32'd0);
    cyc(0, 0, 0, 0);
    chk("ped_short_c12", 32'(bus.state_o), 32'd1);
    repeat (7) cyc(0, 0, 0, 0);
    chk("ped_held_c19", 32'(bus.ped_pending_o), 32'd1);
    cyc(0, 0, 0, 0);
    chk("ped_clr_state", 32'(bus.state_o), 32'd2);
    chk("ped_clr", 32'(bus.ped_pending_o), 32'd0);

    // Request on the ALLRED_A entry edge shortens EW_GREEN
    cyc(1, 0, 0, 0);
    repeat (27) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("edge_state", 32'(bus.state_o), 32'd2);
    chk("edge_pend", 32'(bus.ped_pending_o), 32'd1);
    repeat (11) cyc(0, 0, 0, 0);
    chk("edge_c39", 32'(bus.state_o), 32'd3);
    cyc(0, 0, 0, 0);
    chk("edge_c40", 32'(bus.state_o), 32'd4);

    // Reset in EW_YELLOW
    repeat (2) cyc(0, 0, 0, 0);
    chk("pre_rst_pend", 32'(bus.ped_pending_o), 32'd1);
    cyc(1, 0, 0, 0);
    chk("mid_rst_state", 32'(bus.state_o), 32'd0);
    chk("mid_rst_ns", 32'(bus.ns_o), 32'b100);
    chk("mid_rst_ew", 32'(bus.ew_o), 32'b001);
    chk("mid_rst_pend", 32'(bus.ped_pending_o), 32'd0);
    repeat (2) cyc(0, 0, 0, 0);
    chk("mid_rst_tick_c2", 32'(bus.tick_o), 32'd0);
    cyc(0, 0, 0, 0);
    chk("mid_rst_tick_c3", 32'(bus.tick_o), 32'd1);

`ifdef TRAFFIC_FLASH_MODE_EN
    // Flash entry during EW_GREEN, alternation, exit via ALLRED_A
    cyc(1, 0, 0, 0);
    repeat (34) cyc(0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1);
    chk("flash_state", 32'(bus.state_o), 32'd6);
    chk("flash_ns_on", 32'(bus.ns_o), 32'b010);
    chk("flash_ew_on", 32'(bus.ew_o), 32'b010);
    repeat (4) cyc(0, 0, 0, 1);
    chk("flash_ns_off", 32'(bus.ns_o), 32'b000);
    repeat (4) cyc(0, 0, 0, 1);
    chk("flash_ns_on2", 32'(bus.ns_o), 32'b010);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("flash_exit", 32'(bus.state_o), 32'd2);
    chk("flash_exit_ns", 32'(bus.ns_o), 32'b001);
    repeat (3) cyc(0, 0, 0, 0);
    chk("flash_exit_c51", 32'(bus.state_o), 32'd2);
    cyc(0, 0, 0, 0);
    chk("flash_resume", 32'(bus.state_o), 32'd3);
`endif

    // Randomized run against the model
    cyc(1, 0, 0, 0);
    hl = 0; fl = 0;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) hl = !hl;
      if ($urandom_range(0, 60) == 0) fl = !fl;
      rr = ($urandom_range(0, 499) == 0);
      pp = ($urandom_range(0, 19) == 0);
      cyc(rr, hl, pp, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
